// File: rtl/sipo_word_assembler_if.sv
// Bus between the serial bit source, the word assembler and the downstream PIPO stage.
// A bit moves when s_valid && s_ready at a rising edge; a word moves when load && out_ready.
interface sipo_word_assembler_if #(
    parameter int WIDTH = 4
);
    localparam int CW = $clog2(WIDTH + 1);

    logic            s_valid;
    logic            s_in;
    logic            s_ready;
    logic [WIDTH-1:0] p_out;
    logic            load;
    logic            out_ready;
    logic [CW-1:0]   bit_cnt;

    modport master (
        output s_valid, s_in, out_ready,
        input  s_ready, p_out, load, bit_cnt
    );

    modport slave (
        input  s_valid, s_in, out_ready,
        output s_ready, p_out, load, bit_cnt
    );
endinterface

// File: rtl/sipo_word_assembler.sv
// Serial-to-parallel word assembler: shifts in accepted bits and presents each
// completed WIDTH-bit word on p_out/load, holding one extra word under back-pressure.
module sipo_word_assembler #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  clr,
    sipo_word_assembler_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_p_out;
    logic             r_load;
    logic [CW-1:0]    r_bit_cnt;

    logic [WIDTH-1:0] w_sh_next;
    logic             w_out_free;
    logic             w_s_ready;
    logic             w_accept;

    // bit_cnt == WIDTH is the PENDING state: a full word waits in r_sh for the slot.
    assign w_out_free = !r_load || bus.out_ready;
    assign w_s_ready  = rst && !clr && (r_bit_cnt != CNT_FULL);
    assign w_accept   = bus.s_valid && w_s_ready;

    always_comb begin
        w_sh_next = r_sh;
        if (MSB_FIRST) begin
            w_sh_next = {r_sh[WIDTH-2:0], bus.s_in};
        end else begin
            w_sh_next = {bus.s_in, r_sh[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sh      <= '0;
            r_p_out   <= '0;
            r_load    <= 1'b0;
            r_bit_cnt <= '0;
        end else if (clr) begin
            r_sh      <= '0;
            r_p_out   <= '0;
            r_load    <= 1'b0;
            r_bit_cnt <= '0;
        end else begin
            // A drain drops load unless a new word is written into the slot below.
            if (r_load && bus.out_ready) begin
                r_load <= 1'b0;
            end
            if (r_bit_cnt == CNT_FULL) begin
                if (w_out_free) begin
                    r_p_out   <= r_sh;
                    r_load    <= 1'b1;
                    r_bit_cnt <= '0;
                    r_sh      <= '0;
                end
            end else if (w_accept) begin
                if (r_bit_cnt == CNT_LAST) begin
                    if (w_out_free) begin
                        r_p_out   <= w_sh_next;
                        r_load    <= 1'b1;
                        r_bit_cnt <= '0;
                        r_sh      <= '0;
                    end else begin
                        r_sh      <= w_sh_next;
                        r_bit_cnt <= CNT_FULL;
                    end
                end else begin
                    r_sh      <= w_sh_next;
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.s_ready = w_s_ready;
    assign bus.p_out   = r_p_out;
    assign bus.load    = r_load;
    assign bus.bit_cnt = r_bit_cnt;
endmodule

// File: tb/tb_sipo_word_assembler.sv
// Directed bench for sipo_word_assembler: one MSB-first and one LSB-first instance
// sharing clock, reset and clear.
module tb_sipo_word_assembler;
    logic clk;
    logic rst;
    logic clr;

    int tests_run;
    int tests_failed;

    sipo_word_assembler_if #(.WIDTH(4)) m_if ();
    sipo_word_assembler_if #(.WIDTH(4)) l_if ();

    sipo_word_assembler #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (m_if.slave)
    );

    sipo_word_assembler #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (l_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic send_m(input logic [3:0] word);
        for (int i = 3; i >= 0; i--) begin
            @(negedge clk);
            m_if.s_valid = 1'b1;
            m_if.s_in    = word[i];
        end
        @(negedge clk);
        m_if.s_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] bits_l;
        logic [7:0] stream;

        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b0;
        clr          = 1'b0;
        m_if.s_valid = 1'b0;
        m_if.s_in    = 1'b0;
        m_if.out_ready = 1'b1;
        l_if.s_valid = 1'b0;
        l_if.s_in    = 1'b0;
        l_if.out_ready = 1'b1;

        // Reset state
        #2;
        check("rst_s_ready", 32'(m_if.s_ready), 32'h0);
        check("rst_load",    32'(m_if.load),    32'h0);
        check("rst_p_out",   32'(m_if.p_out),   32'h0);
        check("rst_bit_cnt", 32'(m_if.bit_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rel_s_ready", 32'(m_if.s_ready), 32'h1);

        // MSB-first word 1,0,1,1 on consecutive cycles
        for (int i = 3; i >= 0; i--) begin
            @(negedge clk);
            if (i == 1) check("msb_cnt2", 32'(m_if.bit_cnt), 32'h2);
            m_if.s_valid = 1'b1;
            m_if.s_in    = (i == 2) ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        m_if.s_valid = 1'b0;
        check("msb_p_out", 32'(m_if.p_out),   32'hB);
        check("msb_load",  32'(m_if.load),    32'h1);
        check("msb_cnt0",  32'(m_if.bit_cnt), 32'h0);
        @(negedge clk);
        check("msb_load_1cyc", 32'(m_if.load),  32'h0);
        check("msb_p_hold",    32'(m_if.p_out), 32'hB);

        // LSB-first 1,0,1,1 with 3 idle cycles between bits
        bits_l = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 2) check("lsb_cnt_gap", 32'(l_if.bit_cnt), 32'h2);
            l_if.s_valid = 1'b1;
            l_if.s_in    = bits_l[i];
            @(negedge clk);
            l_if.s_valid = 1'b0;
            if (i < 3) begin
                repeat (2) @(negedge clk);
            end
        end
        check("lsb_p_out", 32'(l_if.p_out),   32'hD);
        check("lsb_load",  32'(l_if.load),    32'h1);
        check("lsb_cnt0",  32'(l_if.bit_cnt), 32'h0);
        @(negedge clk);
        check("lsb_load_1cyc", 32'(l_if.load), 32'h0);

        // Back-pressure: 4'hA then 4'h5 with out_ready low
        m_if.out_ready = 1'b0;
        send_m(4'hA);
        check("bp_first_load", 32'(m_if.load),  32'h1);
        check("bp_first_word", 32'(m_if.p_out), 32'hA);
        send_m(4'h5);
        check("bp_pending_cnt",   32'(m_if.bit_cnt), 32'h4);
        check("bp_pending_ready", 32'(m_if.s_ready), 32'h0);
        check("bp_hold_word",     32'(m_if.p_out),   32'hA);
        check("bp_hold_load",     32'(m_if.load),    32'h1);
        @(negedge clk);
        check("bp_still_word", 32'(m_if.p_out), 32'hA);
        m_if.out_ready = 1'b1;
        #1;
        check("bp_xfer_ready", 32'(m_if.s_ready), 32'h0);
        @(negedge clk);
        m_if.out_ready = 1'b0;
        check("bp_second_word", 32'(m_if.p_out),   32'h5);
        check("bp_second_load", 32'(m_if.load),    32'h1);
        check("bp_ready_back",  32'(m_if.s_ready), 32'h1);
        check("bp_cnt0",        32'(m_if.bit_cnt), 32'h0);
        @(negedge clk);
        check("bp_load_held", 32'(m_if.load), 32'h1);
        m_if.out_ready = 1'b1;
        @(negedge clk);
        check("bp_drained", 32'(m_if.load), 32'h0);

        // Continuous 8-bit stream: 4'hC then 4'h3
        stream = 8'hC3;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            if (i == 3) begin
                check("cont_word0", 32'(m_if.p_out),   32'hC);
                check("cont_load0", 32'(m_if.load),    32'h1);
                check("cont_ready", 32'(m_if.s_ready), 32'h1);
            end
            if (i == 2) check("cont_gap0", 32'(m_if.load), 32'h0);
            m_if.s_valid = 1'b1;
            m_if.s_in    = stream[i];
        end
        @(negedge clk);
        m_if.s_valid = 1'b0;
        check("cont_word1", 32'(m_if.p_out), 32'h3);
        check("cont_load1", 32'(m_if.load),  32'h1);
        @(negedge clk);
        check("cont_gap1", 32'(m_if.load), 32'h0);

        // Two bits, clr pulse, then 0,1,1,0
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            m_if.s_valid = 1'b1;
            m_if.s_in    = 1'b1;
        end
        @(negedge clk);
        m_if.s_valid = 1'b1;
        clr          = 1'b1;
        #1;
        check("clr_s_ready", 32'(m_if.s_ready), 32'h0);
        @(negedge clk);
        clr          = 1'b0;
        m_if.s_valid = 1'b0;
        check("clr_cnt0", 32'(m_if.bit_cnt), 32'h0);
        send_m(4'h6);
        check("clr_word", 32'(m_if.p_out), 32'h6);
        check("clr_load", 32'(m_if.load),  32'h1);
        @(negedge clk);
        check("clr_single_load", 32'(m_if.load), 32'h0);

        // Async reset while load is high
        send_m(4'hB);
        check("arst_pre_load", 32'(m_if.load), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_load",    32'(m_if.load),    32'h0);
        check("arst_p_out",   32'(m_if.p_out),   32'h0);
        check("arst_cnt",     32'(m_if.bit_cnt), 32'h0);
        check("arst_s_ready", 32'(m_if.s_ready), 32'h0);
        @(negedge clk);
        check("arst_held_ready", 32'(m_if.s_ready), 32'h0);
        rst = 1'b1;
        #1;
        check("arst_ready_back", 32'(m_if.s_ready), 32'h1);

        // Reset mid-word loses the partial word
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            m_if.s_valid = 1'b1;
            m_if.s_in    = 1'b1;
        end
        @(negedge clk);
        m_if.s_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("mid_rst_cnt", 32'(m_if.bit_cnt), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        send_m(4'h9);
        check("mid_rst_word", 32'(m_if.p_out), 32'h9);
        check("mid_rst_load", 32'(m_if.load),  32'h1);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
